// File: rtl/ahb_slave_resp_mux_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_resp_mux_if
// Bus bundle between the address decoder/master side and the slave-side
// response mux of one interconnect layer.
//   hsel        : address-phase slave select (expected one-hot)
//   htrans      : address-phase HTRANS from the master
//   payload_in  : per-slave {hreadyout, hresp, hrdata} payloads
//   hready_out  : shared HREADY to master and slaves
//   hresp_out   : HRESP to the master
//   hrdata_out  : HRDATA to the master
//   dsel_out    : registered data-phase select
// Modports: master drives the request/payload side, slave is the mux view.
// ---------------------------------------------------------------------------
interface ahb_slave_resp_mux_if #(
  parameter int SLV_NUM  = 4,
  parameter int DATA_W   = 32,
  parameter int PAY_LOAD = DATA_W + 2
) ();

  logic [SLV_NUM-1:0]                hsel;
  logic [1:0]                        htrans;
  logic [SLV_NUM-1:0][PAY_LOAD-1:0]  payload_in;
  logic                              hready_out;
  logic                              hresp_out;
  logic [DATA_W-1:0]                 hrdata_out;
  logic [SLV_NUM-1:0]                dsel_out;

  modport master (
    output hsel,
    output htrans,
    output payload_in,
    input  hready_out,
    input  hresp_out,
    input  hrdata_out,
    input  dsel_out
  );

  modport slave (
    input  hsel,
    input  htrans,
    input  payload_in,
    output hready_out,
    output hresp_out,
    output hrdata_out,
    output dsel_out
  );

endinterface

// File: rtl/ahb_slave_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_slave_resp_mux
// Registers the address-phase slave select into the data phase and returns
// the selected slave's {hreadyout, hresp, hrdata} to the master. When no
// slave owns the data phase a built-in default slave answers: zero-wait OKAY
// for idle/busy or inactive cycles, and the two-cycle AHB ERROR response for
// active transfers whose select is not exactly one-hot.
// Ports:
//   HCLK           : clock, all state on rising edge
//   HRESETn        : asynchronous active-low reset
//   bus            : ahb_slave_resp_mux_if.slave (hsel, htrans, payload_in in;
//                    hready_out, hresp_out, hrdata_out, dsel_out out)
//   decode_err_clr : synchronous clear of decode_err
//   decode_err     : sticky flag, active transfer with a non-one-hot select
// ---------------------------------------------------------------------------
module ahb_slave_resp_mux #(
  parameter int SLV_NUM  = 4,
  parameter int DATA_W   = 32,
  parameter int PAY_LOAD = DATA_W + 2
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  ahb_slave_resp_mux_if.slave      bus,
  input  logic                     decode_err_clr,
  output logic                     decode_err
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // Full-width scan: never truncates the select, works down to SLV_NUM=1.
  function automatic logic is_onehot(input logic [SLV_NUM-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < SLV_NUM; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end else begin
        multi = multi;
      end
    end
    return seen & ~multi;
  endfunction

  logic [SLV_NUM-1:0]  dsel_r;
  ds_state_t           ds_state_r;
  logic                ds_hready_r;
  logic                ds_hresp_r;
  logic                decode_err_r;

  logic                valid_sel_s;
  logic                active_s;
  logic                accept_s;
  logic                err_start_s;
  logic [PAY_LOAD-1:0] mux_payload_s;
  logic                hready_s;
  logic                hresp_s;
  logic [DATA_W-1:0]   hrdata_s;

  assign valid_sel_s = is_onehot(bus.hsel);
  assign active_s    = bus.htrans[1];
  // Any cycle with HREADY high closes the data phase and accepts the address phase.
  assign accept_s    = hready_s;
  assign err_start_s = accept_s & ~valid_sel_s & active_s;

  // Data-phase select: captured on accept, held through wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_r <= {SLV_NUM{1'b0}};
    end else if (accept_s) begin
      if (valid_sel_s) begin
        dsel_r <= bus.hsel;
      end else begin
        dsel_r <= {SLV_NUM{1'b0}};
      end
    end else begin
      dsel_r <= dsel_r;
    end
  end

  // Default-slave FSM with registered HREADY/HRESP.
  // ERR1 is only reachable with dsel=0, and dsel cannot change in ERR1
  // (HREADY is low), so the error sequence always runs with dsel=0.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ds_state_r  <= DS_IDLE;
      ds_hready_r <= 1'b1;
      ds_hresp_r  <= 1'b0;
    end else begin
      case (ds_state_r)
        DS_IDLE, DS_ERR2: begin
          if (err_start_s) begin
            ds_state_r  <= DS_ERR1;
            ds_hready_r <= 1'b0;
            ds_hresp_r  <= 1'b1;
          end else begin
            ds_state_r  <= DS_IDLE;
            ds_hready_r <= 1'b1;
            ds_hresp_r  <= 1'b0;
          end
        end
        DS_ERR1: begin
          ds_state_r  <= DS_ERR2;
          ds_hready_r <= 1'b1;
          ds_hresp_r  <= 1'b1;
        end
        default: begin
          ds_state_r  <= DS_IDLE;
          ds_hready_r <= 1'b1;
          ds_hresp_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky decode error flag; a new error wins over a same-cycle clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      decode_err_r <= 1'b0;
    end else if (err_start_s) begin
      decode_err_r <= 1'b1;
    end else if (decode_err_clr) begin
      decode_err_r <= 1'b0;
    end else begin
      decode_err_r <= decode_err_r;
    end
  end

  // AND-OR payload mux; dsel is one-hot or zero by construction.
  always_comb begin
    mux_payload_s = {PAY_LOAD{1'b0}};
    for (int i = 0; i < SLV_NUM; i++) begin
      mux_payload_s = mux_payload_s | (bus.payload_in[i] & {PAY_LOAD{dsel_r[i]}});
    end
    if (dsel_r == {SLV_NUM{1'b0}}) begin
      hready_s = ds_hready_r;
      hresp_s  = ds_hresp_r;
      hrdata_s = {DATA_W{1'b0}};
    end else begin
      hready_s = mux_payload_s[DATA_W+1];
      hresp_s  = mux_payload_s[DATA_W];
      hrdata_s = mux_payload_s[DATA_W-1:0];
    end
  end

  assign bus.hready_out = hready_s;
  assign bus.hresp_out  = hresp_s;
  assign bus.hrdata_out = hrdata_s;
  assign bus.dsel_out   = dsel_r;
  assign decode_err     = decode_err_r;

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_resp_mux
// Directed, table-driven bench for ahb_slave_resp_mux. Each table row is one
// clock cycle: inputs are driven on the falling edge and the outputs expected
// for that cycle are compared 1 time unit later. Extra hand-written sequences
// cover asynchronous reset during ERR1 and a 16-slave instance.
// ---------------------------------------------------------------------------
module tb_ahb_slave_resp_mux;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic clr;
  logic derr;
  logic clr16;
  logic derr16;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_resp_mux_if #(.SLV_NUM(4), .DATA_W(32)) bus ();
  ahb_slave_resp_mux_if #(.SLV_NUM(16), .DATA_W(32)) bus16 ();

  ahb_slave_resp_mux #(.SLV_NUM(4), .DATA_W(32)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .bus            (bus),
    .decode_err_clr (clr),
    .decode_err     (derr)
  );

  ahb_slave_resp_mux #(.SLV_NUM(16), .DATA_W(32)) dut16 (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .bus            (bus16),
    .decode_err_clr (clr16),
    .decode_err     (derr16)
  );

  typedef struct {
    logic [3:0]  hsel;
    logic [1:0]  htrans;
    logic        clr;
    logic        ov_en;
    int          ov_idx;
    logic [33:0] ov_pay;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    logic [3:0]  e_dsel;
    logic        e_derr;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [3:0] hsel, input logic [1:0] ht,
                              input logic c, input logic ov_en, input int idx,
                              input logic [33:0] pay, input logic rdy,
                              input logic resp, input logic [31:0] data,
                              input logic [3:0] dsel, input logic de);
    vec_t v;
    v.hsel = hsel;   v.htrans = ht;    v.clr = c;
    v.ov_en = ov_en; v.ov_idx = idx;   v.ov_pay = pay;
    v.e_rdy = rdy;   v.e_resp = resp;  v.e_data = data;
    v.e_dsel = dsel; v.e_derr = de;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic default_payloads();
    for (int i = 0; i < 4; i++) begin
      bus.payload_in[i] = {1'b1, 1'b0, 32'hA000_0000 | 32'(i)};
    end
    for (int i = 0; i < 16; i++) begin
      bus16.payload_in[i] = {1'b1, 1'b0, 32'hB000_0000 | 32'(i)};
    end
  endtask

  task automatic check_main(input string tag, input logic rdy, input logic resp,
                            input logic [31:0] data, input logic [3:0] dsel,
                            input logic de);
    check({tag, " hready"}, 32'(bus.hready_out), 32'(rdy));
    check({tag, " hresp"},  32'(bus.hresp_out),  32'(resp));
    check({tag, " hrdata"}, bus.hrdata_out,      data);
    check({tag, " dsel"},   32'(bus.dsel_out),   32'(dsel));
    check({tag, " derr"},   32'(derr),           32'(de));
  endtask

  initial begin
    // idle / single read slave 2
    vecs[0]  = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    vecs[1]  = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    vecs[2]  = mk(4'b0100, 2'b10, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    vecs[3]  = mk(4'b0000, 2'b00, 1'b0, 1'b1, 2, 34'h2DEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF,  4'b0100, 1'b0);
    // wait-state hold on slave 1, pending select 0001
    vecs[4]  = mk(4'b0010, 2'b10, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    vecs[5]  = mk(4'b0001, 2'b10, 1'b0, 1'b1, 1, 34'h0,         1'b0, 1'b0, 32'h0,         4'b0010, 1'b0);
    vecs[6]  = mk(4'b0001, 2'b10, 1'b0, 1'b1, 1, 34'h0,         1'b0, 1'b0, 32'h0,         4'b0010, 1'b0);
    vecs[7]  = mk(4'b0001, 2'b10, 1'b0, 1'b1, 1, 34'h0,         1'b0, 1'b0, 32'h0,         4'b0010, 1'b0);
    vecs[8]  = mk(4'b0001, 2'b10, 1'b0, 1'b1, 1, 34'h211112222, 1'b1, 1'b0, 32'h11112222,  4'b0010, 1'b0);
    vecs[9]  = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'hA0000000,  4'b0001, 1'b0);
    // unmapped NONSEQ, then clear
    vecs[10] = mk(4'b0000, 2'b10, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    vecs[11] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 1'b1);
    vecs[12] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b1, 32'h0,         4'b0000, 1'b1);
    vecs[13] = mk(4'b0000, 2'b00, 1'b1, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b1);
    vecs[14] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    // multi-hot SEQ, back-to-back unmapped error, then valid from ERR2
    vecs[15] = mk(4'b0011, 2'b11, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    vecs[16] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 1'b1);
    vecs[17] = mk(4'b0000, 2'b10, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b1, 32'h0,         4'b0000, 1'b1);
    vecs[18] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 1'b1);
    vecs[19] = mk(4'b1000, 2'b10, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b1, 32'h0,         4'b0000, 1'b1);
    vecs[20] = mk(4'b0000, 2'b00, 1'b1, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'hA0000003,  4'b1000, 1'b1);
    // set beats clear in the same cycle
    vecs[21] = mk(4'b0110, 2'b10, 1'b1, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
    vecs[22] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 1'b1);
    vecs[23] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b1, 32'h0,         4'b0000, 1'b1);
    // invalid select with BUSY: plain OKAY
    vecs[24] = mk(4'b0000, 2'b01, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b1);
    vecs[25] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b1);
    // slave-generated two-cycle ERROR passes through
    vecs[26] = mk(4'b0001, 2'b10, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b1);
    vecs[27] = mk(4'b0000, 2'b00, 1'b0, 1'b1, 0, 34'h100000000, 1'b0, 1'b1, 32'h0,         4'b0001, 1'b1);
    vecs[28] = mk(4'b0000, 2'b00, 1'b0, 1'b1, 0, 34'h300000000, 1'b1, 1'b1, 32'h0,         4'b0001, 1'b1);
    vecs[29] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 0, 34'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 1'b1);

    // reset: idle inputs, HRESETn low for 3 cycles
    bus.hsel = 4'b0000;    bus.htrans = 2'b00;   clr = 1'b0;
    bus16.hsel = 16'h0000; bus16.htrans = 2'b00; clr16 = 1'b0;
    default_payloads();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    #1;
    check_main("reset", 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
    HRESETn = 1'b1;

    // table
    for (int r = 0; r < NV; r++) begin
      @(negedge HCLK);
      bus.hsel   = vecs[r].hsel;
      bus.htrans = vecs[r].htrans;
      clr        = vecs[r].clr;
      default_payloads();
      if (vecs[r].ov_en) begin
        bus.payload_in[vecs[r].ov_idx] = vecs[r].ov_pay;
      end
      #1;
      check_main($sformatf("row%0d", r), vecs[r].e_rdy, vecs[r].e_resp,
                 vecs[r].e_data, vecs[r].e_dsel, vecs[r].e_derr);
    end

    // asynchronous reset in the middle of DS_ERR1
    @(negedge HCLK);
    bus.hsel = 4'b0000; bus.htrans = 2'b10; clr = 1'b0;
    default_payloads();
    #1;
    check("areset pre hready", 32'(bus.hready_out), 32'h1);
    @(negedge HCLK);
    bus.htrans = 2'b00;
    #1;
    check("areset err1 hready", 32'(bus.hready_out), 32'h0);
    check("areset err1 hresp",  32'(bus.hresp_out),  32'h1);
    #1;
    HRESETn = 1'b0;
    #1;
    check_main("areset", 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // 16-slave instance: top select bit must not be truncated
    @(negedge HCLK);
    bus16.hsel = 16'h8000; bus16.htrans = 2'b10;
    @(negedge HCLK);
    bus16.hsel = 16'h0000; bus16.htrans = 2'b00;
    #1;
    check("s16 dsel",   32'(bus16.dsel_out),  32'h0000_8000);
    check("s16 hrdata", bus16.hrdata_out,     32'hB000_000F);
    check("s16 hready", 32'(bus16.hready_out), 32'h1);
    @(negedge HCLK);
    bus16.hsel = 16'h8001; bus16.htrans = 2'b10;
    #1;
    check("s16 pre dsel", 32'(bus16.dsel_out), 32'h0);
    @(negedge HCLK);
    bus16.hsel = 16'h0000; bus16.htrans = 2'b00;
    #1;
    check("s16 err1 hready", 32'(bus16.hready_out), 32'h0);
    check("s16 err1 hresp",  32'(bus16.hresp_out),  32'h1);
    check("s16 derr",        32'(derr16),           32'h1);
    check("s4 quiet derr",   32'(derr),             32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_resp_mux.md
Name: ahb_slave_resp_mux

Overview:
- Parametrised successor to the combinational one-hot slave-side payload mux.
- Registers the address-phase slave select into the data phase, as AHB requires, and returns the selected slave's HRDATA/HRESP/HREADYOUT to the master.
- Generates the shared HREADY.
- Contains a built-in default slave that produces the two-cycle AHB ERROR response for unmapped or multiply-decoded active transfers.
- Sits between the address decoder and the master port of one layer of the generated interconnect.

Parameters:
- SLV_NUM, 4, number of slave channels (1..16).
- DATA_W, 32, HRDATA width (32 or 64).
- PAY_LOAD, DATA_W+2, per-slave payload width; layout is {hreadyout, hresp, hrdata[DATA_W-1:0]}, MSB first.

Ports:
- HCLK  input  1  system clock, all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- hsel  input  SLV_NUM  address-phase slave select from the decoder, expected one-hot.
- htrans  input  2  address-phase HTRANS from the master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- payload_in  input  SLV_NUM x PAY_LOAD  packed per-slave response payloads.
- decode_err_clr  input  1  synchronous clear of the decode_err flag.
- hready_out  output  1  HREADY to the master and to all slaves.
- hresp_out  output  1  HRESP to the master (0 OKAY, 1 ERROR).
- hrdata_out  output  DATA_W  HRDATA to the master.
- dsel_out  output  SLV_NUM  registered data-phase select.
- decode_err  output  1  sticky flag: an active transfer had hsel with zero or more than one bit set.

Behaviour:
- Reset (HRESETn=0, asynchronous):
  - dsel=0, default-slave state DS_IDLE, decode_err=0.
  - Outputs: hready_out=1, hresp_out=0, hrdata_out=0.
- Address-phase accept happens on any rising edge where hready_out=1. The accept cycle is the one-cycle boundary between address and data phase.
- Valid select means hsel is exactly one-hot.
- On accept:
  - Valid select: dsel <= hsel.
  - Invalid select: dsel <= 0.
- When hready_out=0, dsel holds. hsel and htrans are ignored.
- Output mux, combinational from dsel and payload_in:
  - dsel one-hot on slave i: {hready_out, hresp_out, hrdata_out} = payload_in[i]. Output latency from slave payload is zero cycles.
  - dsel=0: outputs come from the default slave (below).
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: hready_out=1, hresp_out=0, hrdata_out=0. On accept with invalid select and htrans[1]=1 -> DS_ERR1. Otherwise stay.
  - DS_ERR1: hready_out=0, hresp_out=1, hrdata_out=0. Always -> DS_ERR2.
  - DS_ERR2: hready_out=1, hresp_out=1, hrdata_out=0. This cycle is an accept cycle.
    - New invalid active transfer -> DS_ERR1 (back-to-back errors).
    - Otherwise -> DS_IDLE.
  - Invalid select with htrans IDLE/BUSY: no error response; zero-wait OKAY via DS_IDLE.
  - The FSM advances only while dsel=0. Accepting a valid select from DS_ERR2 moves the FSM to DS_IDLE, and slave i drives from the next cycle.
- decode_err:
  - Set on accept when hsel has more than one bit set, or zero bits set, with htrans[1]=1.
  - Cleared by decode_err_clr=1 on the next edge.
  - Set has priority over clear in the same cycle.
- Slave wait states: while the selected slave drives hreadyout=0, hready_out=0 and dsel holds. A pending address phase (new hsel) is not captured until hready_out=1.
- Reset mid-transfer, including mid-ERR1: everything returns to reset values immediately. No response completes.
- SLV_NUM=1 must elaborate. The select comparison must not truncate for SLV_NUM=16.

Test Plan:
- Reset then idle: HRESETn low 3 cycles, then htrans=00, hsel=0 -> hready_out=1, hresp_out=0, hrdata_out=0, dsel_out=0 throughout.
- Single read, slave 2:
  - Stimulus: hsel=0100, htrans=10 in cycle N; payload_in[2]={1,0,32'hDEAD_BEEF} in N+1.
  - Response: dsel_out=0100 in N+1; hrdata_out=DEAD_BEEF, hready_out=1, hresp_out=0 in N+1.
- Wait-state hold:
  - Stimulus: slave 1 selected; payload_in[1] hreadyout=0 for 3 cycles; hsel changes to 0001 during the wait.
  - Response: hready_out=0 for 3 cycles; dsel_out stays 0010 until the first cycle with hready_out=1, then becomes 0001.
- Unmapped NONSEQ:
  - Stimulus: hsel=0000, htrans=10.
  - Response: next cycle hready_out=0, hresp_out=1; following cycle hready_out=1, hresp_out=1; then OKAY. decode_err=1 until decode_err_clr pulses.
- Multi-hot, then back-to-back errors:
  - Stimulus: hsel=0011 with htrans=11, and again hsel=0000 with htrans=10 in the DS_ERR2 cycle.
  - Response: sequence ERR1, ERR2, ERR1, ERR2; hresp_out=1 for 4 cycles.
- Async reset during DS_ERR1: HRESETn dropped mid-cycle -> hready_out=1, hresp_out=0 and dsel_out=0 immediately, without waiting for HCLK.
